// File: rtl/cbd_coeff_collector.sv
// Collects sparse CBD sampler beats into a small FIFO and streams them out as
// indexed coefficients in [0, Q-1], one polynomial of N coefficients per start.
module cbd_coeff_collector #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 4,
  parameter int COEFF_W   = 12,
  parameter int Q         = 3329,
  parameter int N         = 256,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [LANES*CAND_BITS-1:0] sampled_vals,
  input  logic [LANES-1:0]           accepted_flags,
  output logic                       coef_valid,
  input  logic                       coef_ready,
  output logic [COEFF_W-1:0]         coef_data,
  output logic [$clog2(N)-1:0]       coef_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int AW        = $clog2(N);
  localparam int CNTW      = $clog2(N + 1);
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCCW      = $clog2(DEPTH + 1);
  localparam int LW        = $clog2(LANES + 1);
  localparam int CAND_SPAN = 1 << CAND_BITS;
  localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     pushed_q, pushed_d;
  logic [CNTW-1:0]     emitted_q, emitted_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCCW-1:0]     occ_q, occ_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [COEFF_W-1:0]  fifo_mem [DEPTH];

  logic [LW-1:0]       lane_rank  [LANES];
  logic [COEFF_W-1:0]  lane_coeff [LANES];
  logic [PW-1:0]       lane_slot  [LANES];
  logic [LANES-1:0]    lane_take;

  logic [LW-1:0]       beat_total;
  logic [CNTW-1:0]     remaining;
  logic [CNTW-1:0]     n_push;
  logic                beat_live, do_push, do_drop, do_pop;

  function automatic logic [PW-1:0] wrap_ptr(input logic [PW:0] v);
    if (v >= DEPTH_P) return PW'(v - DEPTH_P);
    return v[PW-1:0];
  endfunction

  // Each lane's rank among accepted lanes gives its compacted FIFO slot.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [CAND_BITS-1:0] raw;
      logic [PW:0]          slot_sum;
      assign raw = sampled_vals[gi*CAND_BITS +: CAND_BITS];
      if (gi == 0) begin : g_first
        assign lane_rank[gi] = '0;
      end else begin : g_rest
        assign lane_rank[gi] = lane_rank[gi-1] + LW'(accepted_flags[gi-1]);
      end
      assign lane_coeff[gi] = raw[CAND_BITS-1] ? COEFF_W'(Q - CAND_SPAN + int'(raw))
                                               : COEFF_W'(raw);
      assign slot_sum      = (PW + 1)'(wr_ptr_q) + (PW + 1)'(lane_rank[gi]);
      assign lane_slot[gi] = wrap_ptr(slot_sum);
      assign lane_take[gi] = accepted_flags[gi] && (CNTW'(lane_rank[gi]) < n_push);
    end
  endgenerate

  assign beat_total = lane_rank[LANES-1] + LW'(accepted_flags[LANES-1]);
  assign remaining  = CNTW'(N) - pushed_q;
  assign n_push     = (CNTW'(beat_total) > remaining) ? remaining : CNTW'(beat_total);
  assign beat_live  = (state_q == S_COLLECT) && in_valid && (n_push != '0);
  // Room is judged on current occupancy only; a pop in this cycle does not help.
  assign do_push    = beat_live && (int'(n_push) <= DEPTH - int'(occ_q));
  assign do_drop    = beat_live && !do_push;

  assign busy       = (state_q != S_IDLE);
  assign coef_valid = busy && (occ_q != '0);
  assign coef_data  = coef_valid ? fifo_mem[rd_ptr_q] : '0;
  assign coef_addr  = emitted_q[AW-1:0];
  assign do_pop     = coef_valid && coef_ready;
  assign done       = done_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    pushed_d   = pushed_q;
    emitted_d  = emitted_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COLLECT;
          pushed_d   = '0;
          emitted_d  = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          occ_d      = '0;
          overflow_d = 1'b0;
        end
      end
      default: begin
        if (do_push) begin
          wr_ptr_d = wrap_ptr((PW + 1)'(wr_ptr_q) + (PW + 1)'(n_push));
          pushed_d = pushed_q + n_push;
        end
        if (do_drop) overflow_d = 1'b1;
        if (do_pop) begin
          rd_ptr_d  = wrap_ptr((PW + 1)'(rd_ptr_q) + (PW + 1)'(1));
          emitted_d = emitted_q + CNTW'(1);
        end
        occ_d = occ_q + (do_push ? OCCW'(n_push) : OCCW'(0)) - OCCW'(do_pop);
        if (state_q == S_COLLECT && pushed_d == CNTW'(N)) state_d = S_DRAIN;
        if (emitted_d == CNTW'(N)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pushed_q   <= '0;
      emitted_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pushed_q   <= pushed_d;
      emitted_q  <= emitted_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (do_push && lane_take[i]) fifo_mem[lane_slot[i]] <= lane_coeff[i];
    end
  end

endmodule

// File: tb/tb_cbd_coeff_collector.sv
// Scoreboard bench for cbd_coeff_collector: expected coefficients are queued
// as beats are driven and compared as the DUT hands them over.
module tb_cbd_coeff_collector;
  localparam int Q = 3329;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] sampled_vals = '0;
  logic [3:0]  accepted_flags = '0;
  logic        coef_ready = 1'b0;
  logic        coef_valid;
  logic [11:0] coef_data;
  logic [7:0]  coef_addr;
  logic        busy, done, overflow;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int mdl_pushed = 0;
  int exp_addr_q[$];
  int exp_data_q[$];

  cbd_coeff_collector dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .sampled_vals(sampled_vals), .accepted_flags(accepted_flags),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_addr(coef_addr), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int conv(input logic [3:0] s);
    if (s[3]) return Q - 16 + int'(s);
    return int'(s);
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [15:0] vals, input logic [3:0] flags, input bit store);
    int n;
    int taken;
    sampled_vals   = vals;
    accepted_flags = flags;
    in_valid       = 1'b1;
    if (store) begin
      n = $countones(flags);
      if (n > N - mdl_pushed) n = N - mdl_pushed;
      taken = 0;
      for (int i = 0; i < 4; i++) begin
        if (flags[i] && taken < n) begin
          exp_addr_q.push_back(mdl_pushed);
          exp_data_q.push_back(conv(vals[i*4 +: 4]));
          mdl_pushed++;
          taken++;
        end
      end
    end
    cycles(1);
    in_valid       = 1'b0;
    accepted_flags = '0;
  endtask

  task automatic send_paced(input logic [15:0] vals, input logic [3:0] flags);
    send_beat(vals, flags, 1'b1);
    cycles(3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    mdl_pushed = 0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    coef_ready = 1'b0;
    in_valid   = 1'b0;
    cycles(2);
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    mdl_pushed = 0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < bound) begin
      cycles(1);
      k++;
    end
    check({tag, "_done_seen"}, (done_cnt != d0), 1);
    cycles(10);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_drained"}, exp_addr_q.size(), 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_no_ovf"}, overflow, 0);
  endtask

  // Transfers happen at the next rising edge when valid and ready are seen here.
  always @(negedge clk) begin
    int ea;
    int ed;
    if (done === 1'b1) begin
      done_cnt++;
      check("done_busy_low", busy, 0);
    end
    if (coef_valid === 1'b1 && coef_ready === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("spurious_xfer", 1, 0);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        $display("xfer addr=%0d data=%0d exp_addr=%0d exp_data=%0d", coef_addr, coef_data, ea, ed);
        check("xfer_addr", coef_addr, ea);
        check("xfer_data", coef_data, ed);
      end
    end
  end

  initial begin
    int  d0;
    int  beats;
    bit  hit;

    cycles(3);
    check("rst_valid", coef_valid, 0);
    check("rst_data", coef_data, 0);
    check("rst_addr", coef_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    cycles(1);

    // Full polynomial, paced so the FIFO never fills.
    coef_ready = 1'b1;
    pulse_start();
    check("full_busy", busy, 1);
    for (int b = 0; b < 64; b++) send_paced(16'($urandom), 4'hF);
    wait_done("full", 200);

    // Lane compaction and sign conversion; in_valid ignored in IDLE.
    send_beat(16'h1234, 4'hF, 1'b0);
    cycles(3);
    check("idle_ignore_valid", coef_valid, 0);
    pulse_start();
    send_beat(16'h5555, 4'h0, 1'b1);
    check("zero_flags_noop", coef_valid, 0);
    send_beat(16'h0DF1, 4'b1011, 1'b1);
    check("latency_valid", coef_valid, 1);
    check("latency_addr", coef_addr, 0);
    cycles(6);
    check("compact_drained", exp_addr_q.size(), 0);
    check("compact_no_ovf", overflow, 0);
    do_reset();

    // Back-to-back beats with a stalled consumer overflow the FIFO.
    pulse_start();
    send_beat(16'h7A31, 4'hF, 1'b1);
    send_beat(16'h0F8C, 4'hF, 1'b1);
    send_beat(16'h4444, 4'hF, 1'b0);
    check("ovf_set", overflow, 1);
    check("stall_valid", coef_valid, 1);
    check("stall_addr", coef_addr, 0);
    check("stall_data", coef_data, exp_data_q[0]);
    cycles(2);
    check("stall_addr_hold", coef_addr, 0);
    check("stall_data_hold", coef_data, exp_data_q[0]);
    coef_ready = 1'b1;
    cycles(12);
    check("ovf_drained", exp_addr_q.size(), 0);
    check("ovf_empty_valid", coef_valid, 0);
    check("ovf_still_busy", busy, 1);
    check("ovf_sticky", overflow, 1);
    do_reset();

    // Tail clipping at pushed=254, stray start while busy, beats ignored in DRAIN.
    coef_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < 63; b++) begin
      send_paced(16'($urandom), 4'hF);
      if (b == 20) begin
        start = 1'b1;
        cycles(1);
        start = 1'b0;
      end
    end
    send_paced(16'($urandom), 4'b0011);
    send_beat(16'h9F21, 4'hF, 1'b1);
    check("tail_drain_busy", busy, 1);
    send_beat(16'h3333, 4'hF, 1'b0);
    wait_done("tail", 200);

    // Reset while offering address 100 abandons the polynomial.
    pulse_start();
    beats = 0;
    hit   = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      if (coef_valid === 1'b1 && coef_addr == 8'd100) begin
        hit = 1'b1;
      end else if (c % 4 == 0 && beats < 40) begin
        send_beat(16'($urandom), 4'hF, 1'b1);
        beats++;
      end else begin
        cycles(1);
      end
    end
    check("reach_addr100", hit, 1);
    coef_ready = 1'b0;
    reset      = 1'b1;
    d0         = done_cnt;
    cycles(1);
    check("midrst_valid", coef_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", coef_addr, 0);
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    mdl_pushed = 0;
    cycles(3);
    check("midrst_no_done", done_cnt - d0, 0);
    coef_ready = 1'b1;
    pulse_start();
    send_beat(16'h8E12, 4'hF, 1'b1);
    cycles(8);
    check("restart_drained", exp_addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cbd_coeff_collector.md
CBD_COEFF_COLLECTOR -- requirements
Module: cbd_coeff_collector

Interface
REQ-001 SHALL have parameter LANES, default 4, lanes per input beat.
REQ-002 SHALL have parameter CAND_BITS, default 4, signed sample width per lane.
REQ-003 SHALL have parameter COEFF_W, default 12, output coefficient width.
REQ-004 SHALL have parameter Q, default 3329, modulus.
REQ-005 SHALL have parameter N, default 256, coefficients per polynomial.
REQ-006 SHALL have parameter DEPTH, default 8 (>= 2*LANES), FIFO entries.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, begin one polynomial; honoured only in IDLE.
REQ-010 SHALL have port in_valid, input, 1, sampler beat valid (sampler done).
REQ-011 SHALL have port sampled_vals, input, LANES*CAND_BITS, lane i at bits [i*CAND_BITS +: CAND_BITS].
REQ-012 SHALL have port accepted_flags, input, LANES, lane i sample is usable.
REQ-013 SHALL have port coef_valid, output, 1, coef_data/coef_addr valid.
REQ-014 SHALL have port coef_ready, input, 1, consumer accepts coefficient.
REQ-015 SHALL have port coef_data, output, COEFF_W, coefficient in [0, Q-1].
REQ-016 SHALL have port coef_addr, output, clog2(N), coefficient index 0..N-1.
REQ-017 SHALL have port busy, output, 1, high in COLLECT or DRAIN.
REQ-018 SHALL have port done, output, 1, one-cycle pulse after coefficient N-1 transfers.
REQ-019 SHALL have port overflow, output, 1, sticky: a beat was dropped for lack of room.

Function
REQ-020 SHALL implement states IDLE, COLLECT, DRAIN; IDLE --start--> COLLECT; COLLECT --pushed==N--> DRAIN; DRAIN --emitted==N--> IDLE.
REQ-021 SHALL on IDLE->COLLECT clear pushed count, emitted count, FIFO, and overflow.
REQ-022 SHALL ignore start while busy, and ignore in_valid in IDLE and DRAIN.
REQ-023 SHALL in COLLECT with in_valid compact accepted lanes in ascending lane order into the FIFO in one cycle.
REQ-024 SHALL push only min(popcount(accepted_flags), N-pushed) samples, dropping the surplus highest-index accepted lanes.
REQ-025 SHALL drop the whole beat and set overflow when the number to push exceeds DEPTH minus current occupancy; a same-cycle pop gives no credit.
REQ-026 SHALL interpret each sample as two's complement: s>=0 -> s; s<0 -> Q+s, zero-extended to COEFF_W; conversion before the FIFO write.
REQ-027 SHALL assert coef_valid whenever busy and FIFO non-empty, with coef_data = FIFO head and coef_addr = emitted count.
REQ-028 SHALL pop and increment emitted on coef_valid && coef_ready; coef_data/coef_addr held stable while coef_valid && !coef_ready.
REQ-029 SHALL make a beat pushed at edge t visible on coef_valid in the cycle after edge t (1-cycle latency).
REQ-030 SHALL allow push and pop in the same cycle; occupancy = old + pushed - popped.
REQ-031 SHALL pulse done in the cycle after the transfer of index N-1, with busy low in that same cycle.
REQ-032 SHALL use wrap-around FIFO pointers modulo DEPTH; occupancy never exceeds DEPTH.
REQ-033 SHALL keep all-zero accepted_flags beats as no-ops (no push, no overflow).

Reset
REQ-034 SHALL on reset go to IDLE, empty the FIFO, zero counters, drive coef_valid=0, coef_data=0, coef_addr=0, busy=0, done=0, overflow=0.
REQ-035 SHALL on reset mid-operation abandon the polynomial with no done pulse; the next start begins at coef_addr 0.

Verification
REQ-036 SHALL verify: start, 64 beats all flags 4'b1111, coef_ready=1 -> 256 transfers, addr 0..255 in order, one done pulse, overflow=0.
REQ-037 SHALL verify: lanes {0:4'h1, 1:4'hF, 2:4'hD, 3:4'h0}, flags 4'b1011 -> outputs 1, 3328, 0 in that order (lane 2 skipped).
REQ-038 SHALL verify: coef_ready=0, beats of 4 accepted at 1/cycle -> 2 beats stored, third beat dropped, overflow=1, occupancy 8.
REQ-039 SHALL verify: pushed=254, beat flags 4'b1111 -> only lanes 0,1 pushed; state DRAIN; later beats ignored.
REQ-040 SHALL verify: reset asserted at addr 100 -> next cycle coef_valid=0, busy=0; new start restarts at addr 0.
REQ-041 SHALL verify: start asserted while busy -> no counter clear, transfer sequence unchanged.
